llr_feeder: RTL

LLR_FEEDER -- requirements
Module: llr_feeder

---
 rtl/llr_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/llr_feeder.sv
// llr_feeder: scales and saturates raw channel LLRs, buffers one frame and
// streams it to the decoder as a right-aligned first chunk followed by full chunks.
module llr_feeder #(
    parameter int WIDTH_RAW   = 12,
    parameter int WIDTH_IN    = 8,
    parameter int N_LLRS      = 4,
    parameter int N_V         = 31,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [WIDTH_RAW-1:0]  llr_in,
    input  logic                         llr_valid,
    input  logic                         llr_sof,
    output logic                         llr_ready,
    output logic [N_LLRS*WIDTH_IN-1:0]   dec_data,
    output logic                         dec_first,
    output logic                         dec_valid,
    input  logic                         dec_busy,
    output logic                         frame_err
);
    localparam int NCH = (N_V - 1) / N_LLRS + 1;
    localparam int CHW = N_LLRS * WIDTH_IN;
    localparam int PW  = NCH * CHW;
    localparam int IW  = N_V > 1 ? $clog2(N_V) : 1;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic signed [WIDTH_RAW-1:0] MAXV = WIDTH_RAW'(2 ** (WIDTH_IN - 1) - 1);
    localparam logic signed [WIDTH_RAW-1:0] MINV = -MAXV;

    typedef enum logic [1:0] {IDLE, FILL, SEND_F, SEND} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           c_q, c_d;
    logic [N_V*WIDTH_IN-1:0] frame_q, frame_d;
    logic                    err_q, err_d, ready_q, ready_d, valid_q, valid_d, first_q, first_d;
    logic [CHW-1:0]          data_q, data_d;
    logic signed [WIDTH_RAW-1:0] sh;
    logic [WIDTH_IN-1:0]     sat;
    logic [PW-1:0]           padded;
    logic [IW-1:0]           widx;
    logic [CW-1:0]           sel;
    logic                    xfer, we;

    // LLR 0 sits at the top of frame_q; zero-extending pads the first chunk on the left
    always_comb begin
        sh = llr_in >>> SCALE_SHIFT;
        sat = sh > MAXV ? MAXV[WIDTH_IN-1:0] : sh < MINV ? MINV[WIDTH_IN-1:0] : sh[WIDTH_IN-1:0];
        xfer = llr_valid && ready_q;
        state_d = state_q;
        idx_d = idx_q;
        c_d = c_q;
        frame_d = frame_q;
        err_d = 1'b0;
        we = 1'b0;
        widx = llr_sof ? '0 : idx_q;
        unique case (state_q)
            IDLE: if (xfer) begin
                we = llr_sof;
                err_d = !llr_sof;
                if (llr_sof) begin
                    idx_d = N_V == 1 ? '0 : IW'(1);
                    state_d = N_V == 1 ? SEND_F : FILL;
                end
            end
            FILL: if (xfer) begin
                we = 1'b1;
                err_d = llr_sof;
                idx_d = llr_sof ? IW'(1) : idx_q + IW'(1);
                if (!llr_sof && idx_q == IW'(N_V - 1)) begin
                    idx_d = '0;
                    state_d = SEND_F;
                end
            end
            SEND_F: if (!dec_busy) begin
                state_d = NCH == 1 ? IDLE : SEND;
                c_d = CW'(NCH > 1);
            end
            SEND: begin
                state_d = c_q == CW'(NCH - 1) ? IDLE : SEND;
                c_d = c_q == CW'(NCH - 1) ? '0 : c_q + CW'(1);
            end
            default: ;
        endcase
        for (int i = 0; i < N_V; i++)
            if (we && widx == IW'(i)) frame_d[(N_V-1-i)*WIDTH_IN +: WIDTH_IN] = sat;
        padded = PW'(frame_d);
        ready_d = state_d == IDLE || state_d == FILL;
        valid_d = !ready_d;
        first_d = state_d == SEND_F;
        sel = state_d == SEND ? c_d : '0;
        data_d = '0;
        for (int i = 0; i < NCH; i++)
            if (valid_d && sel == CW'(i)) data_d = padded[(NCH-1-i)*CHW +: CHW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            first_q <= first_d;
            data_q  <= data_d;
        end
    end

    assign llr_ready = ready_q;
    assign dec_valid = valid_q;
    assign dec_first = first_q;
    assign dec_data  = data_q;
    assign frame_err = err_q;
endmodule
